// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between instruction fetch (port 0)
// and load/store (port 1). It issues one word access per cycle and returns each response one cycle later.
module mem_port_arbiter #(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p0_gnt,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,
  output logic        p0_err,
  output logic        p1_gnt,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata,
  output logic        p1_err,
  output logic [31:0] mem_A,
  output logic [31:0] mem_WD,
  output logic        mem_MemWrite,
  input  logic [31:0] mem_RD,
  output logic [4:0]  dbg_state
);

  localparam logic [31:0] LAST_ADDR = 32'(MEM_BYTES - 4);

  // Response owed for the access granted in the previous cycle.
  typedef struct packed {
    logic v;
    logic port;
    logic we;
    logic err;
  } rsp_t;

  logic prio_q, prio_d;
  rsp_t rsp_q, rsp_d;

  logic        p0_bad, p1_bad;
  logic        any_gnt;
  logic        win;
  logic        win_we, win_err;
  logic [31:0] win_addr, win_wdata;
  logic [31:0] rsp_data;

  always_comb begin
    p0_bad = (p0_addr[1:0] != 2'b00) | (p0_addr > LAST_ADDR);
    p1_bad = (p1_addr[1:0] != 2'b00) | (p1_addr > LAST_ADDR);

    // Grants are gated by rst_n so nothing reaches memory while reset is held.
    p0_gnt  = rst_n & p0_req & (~p1_req | ~prio_q);
    p1_gnt  = rst_n & p1_req & (~p0_req |  prio_q);
    any_gnt = p0_gnt | p1_gnt;
    win     = p1_gnt;

    win_we    = win ? p1_we    : p0_we;
    win_err   = win ? p1_bad   : p0_bad;
    win_addr  = win ? p1_addr  : p0_addr;
    win_wdata = win ? p1_wdata : p0_wdata;

    mem_A        = any_gnt ? win_addr  : 32'd0;
    mem_WD       = any_gnt ? win_wdata : 32'd0;
    mem_MemWrite = any_gnt & win_we & ~win_err;

    prio_d     = any_gnt ? ~win : prio_q;
    rsp_d.v    = any_gnt;
    rsp_d.port = win;
    rsp_d.we   = win_we;
    rsp_d.err  = win_err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= 1'b0;
      rsp_q  <= '0;
    end else begin
      prio_q <= prio_d;
      rsp_q  <= rsp_d;
    end
  end

  // Writes and errored accesses return zero. A read that was presented for a bad address is discarded here.
  always_comb begin
    rsp_data  = (rsp_q.we | rsp_q.err) ? 32'd0 : mem_RD;
    p0_rvalid = rsp_q.v & ~rsp_q.port;
    p1_rvalid = rsp_q.v &  rsp_q.port;
    p0_rdata  = p0_rvalid ? rsp_data : 32'd0;
    p1_rdata  = p1_rvalid ? rsp_data : 32'd0;
    p0_err    = p0_rvalid & rsp_q.err;
    p1_err    = p1_rvalid & rsp_q.err;
    dbg_state = {prio_q, rsp_q};
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: behavioural big-endian memory, grant model and response scoreboard.
// Handshake: a request is held with stable fields until gnt; the response pulses rvalid exactly one cycle after gnt.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic [31:0] mem_A, mem_WD, mem_RD;
  logic        mem_MemWrite;
  logic [4:0]  dbg_state;

  typedef struct packed {
    logic        port;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  mem     [0:1023];
  logic [7:0]  ref_mem [0:1023];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          p0_pulses = 0;
  logic        exp_prio;

  mem_port_arbiter #(.MEM_BYTES(1024)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_A(mem_A), .mem_WD(mem_WD), .mem_MemWrite(mem_MemWrite), .mem_RD(mem_RD),
    .dbg_state(dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] init_byte(input int i);
    logic [7:0] b;
    case (i)
      0: b = 8'h11;
      1: b = 8'h22;
      2: b = 8'h33;
      3: b = 8'h44;
      default: b = 8'((i * 7 + 3) & 255);
    endcase
    return b;
  endfunction

  // Memory model: registered read of last cycle's address, synchronous write, big-endian word.
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = init_byte(i);
    mem_RD = 32'd0;
    forever begin
      @(posedge clk);
      mem_RD <= {mem[(mem_A + 0) & 1023], mem[(mem_A + 1) & 1023],
                 mem[(mem_A + 2) & 1023], mem[(mem_A + 3) & 1023]};
      if (mem_MemWrite) begin
        mem[(mem_A + 0) & 1023] = mem_WD[31:24];
        mem[(mem_A + 1) & 1023] = mem_WD[23:16];
        mem[(mem_A + 2) & 1023] = mem_WD[15:8];
        mem[(mem_A + 3) & 1023] = mem_WD[7:0];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
  endtask

  function automatic logic bad_addr(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a > 32'd1020);
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    int b;
    b = int'(a & 32'd1023);
    return {ref_mem[b], ref_mem[(b + 1) & 1023], ref_mem[(b + 2) & 1023], ref_mem[(b + 3) & 1023]};
  endfunction

  // Scoreboard: each granted access owes exactly one response on the following negedge.
  always @(negedge clk) begin
    if (p0_rvalid) p0_pulses++;
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("rsp_p0_rvalid", 32'(p0_rvalid), 32'(!e.port));
      chk("rsp_p1_rvalid", 32'(p1_rvalid), 32'(e.port));
      chk("rsp_err",   32'(e.port ? p1_err : p0_err), 32'(e.err));
      chk("rsp_rdata", e.port ? p1_rdata : p0_rdata, e.rdata);
    end else begin
      chk("idle_rvalid", {30'd0, p1_rvalid, p0_rvalid}, 32'd0);
    end
  end

  // Driver: one request cycle; checks grant and memory port against the model and queues the response.
  task automatic step(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                      input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
    logic e0, e1, win, we, err;
    logic [31:0] a, d;
    exp_t e;
    @(negedge clk);
    p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
    p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
    #1;
    e0 = r0 && (!r1 || !exp_prio);
    e1 = r1 && (!r0 || exp_prio);
    chk("p0_gnt", 32'(p0_gnt), 32'(e0));
    chk("p1_gnt", 32'(p1_gnt), 32'(e1));
    if (e0 || e1) begin
      win = e1;
      we  = win ? w1 : w0;
      a   = win ? a1 : a0;
      d   = win ? d1 : d0;
      err = bad_addr(a);
      chk("mem_A", mem_A, a);
      chk("mem_MemWrite", 32'(mem_MemWrite), 32'(we && !err));
      if (we && !err) begin
        chk("mem_WD", mem_WD, d);
        ref_mem[a]     = d[31:24];
        ref_mem[a + 1] = d[23:16];
        ref_mem[a + 2] = d[15:8];
        ref_mem[a + 3] = d[7:0];
      end
      e.port  = win;
      e.err   = err;
      e.rdata = (we || err) ? 32'd0 : ref_word(a);
      exp_q.push_back(e);
      exp_prio = !win;
    end else begin
      chk("idle_mem_A", mem_A, 32'd0);
      chk("idle_mem_MemWrite", 32'(mem_MemWrite), 32'd0);
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  initial begin
    int pulses_before;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_byte(i);
    exp_prio = 1'b0;
    rst_n = 1'b0;
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'd0; p0_wdata = 32'd0;
    p1_req = 1'b0; p1_we = 1'b0; p1_addr = 32'd0; p1_wdata = 32'd0;

    // Reset values, with a request present to show grants are gated
    repeat (3) @(negedge clk);
    #1;
    chk("rst_p0_gnt", 32'(p0_gnt), 32'd0);
    chk("rst_p1_gnt", 32'(p1_gnt), 32'd0);
    chk("rst_rvalid", {30'd0, p1_rvalid, p0_rvalid}, 32'd0);
    chk("rst_err", {30'd0, p1_err, p0_err}, 32'd0);
    chk("rst_rdata", p0_rdata | p1_rdata, 32'd0);
    chk("rst_mem_A", mem_A, 32'd0);
    chk("rst_mem_WD", mem_WD, 32'd0);
    chk("rst_mem_MemWrite", 32'(mem_MemWrite), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    p0_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // p0 reads word 0 -> 0x11223344
    step(1'b1, 1'b0, 32'h0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    idle();
    // p1 read restores prio to port 0
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'h20, 32'd0);
    // Tie for 4 cycles: p0,p1,p0,p1
    repeat (4) step(1'b1, 1'b0, 32'h0, 32'd0, 1'b1, 1'b0, 32'h4, 32'd0);
    idle();

    // Write then read the same word on the next cycle
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
    step(1'b1, 1'b0, 32'h10, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    idle();
    chk("mem_10", 32'(mem[16]), 32'hDE);
    chk("mem_11", 32'(mem[17]), 32'hAD);
    chk("mem_12", 32'(mem[18]), 32'hBE);
    chk("mem_13", 32'(mem[19]), 32'hEF);

    // Error cases: misaligned write, top legal word, first illegal word, all-ones-aligned
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'h12, 32'hCAFEF00D);
    idle();
    chk("nowr_12", {mem[18], mem[19], mem[20], mem[21]},
        {8'hBE, 8'hEF, init_byte(20), init_byte(21)});
    step(1'b1, 1'b0, 32'h3FC, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    step(1'b1, 1'b0, 32'h400, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'hFFFFFFFC, 32'd0);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'h400, 32'h12345678);
    idle();

    // Reset between a grant and its response edge: response is dropped, prio returns to port 0
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'h8, 32'd0);
    idle();
    @(negedge clk);
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h4;
    #1;
    chk("mid_p0_gnt", 32'(p0_gnt), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_gated_gnt", 32'(p0_gnt), 32'd0);
    p0_req = 1'b0;
    exp_prio = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 32'h0, 32'd0, 1'b1, 1'b0, 32'h4, 32'd0);
    chk("post_rst_tie_p0", 32'(p0_gnt), 32'd1);
    step(1'b1, 1'b0, 32'h0, 32'd0, 1'b1, 1'b0, 32'h4, 32'd0);
    idle();

    // Single requester held 6 cycles with a random aligned address
    p1_addr = 32'd0;
    pulses_before = p0_pulses;
    begin
      logic [31:0] ra;
      ra = 32'($urandom_range(0, 255)) << 2;
      repeat (6) step(1'b1, 1'b0, ra, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    end
    idle();
    idle();
    chk("single_pulses", 32'(p0_pulses - pulses_before), 32'd6);
    chk("single_prio", 32'(dbg_state[4]), 32'd1);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester round-robin arbiter that shares the single-port, byte-addressed data memory (big-endian word, 1024 bytes, registered read, synchronous write) between the instruction-fetch port (port 0) and the load/store port (port 1). It sits between the CPU core and the memory. It issues at most one word access per cycle, checks address range and alignment, and routes the one-cycle-late read data back to the requester that owns it.

## Interface
- MEM_BYTES, 1024: memory size in bytes. Legal word addresses are 0 .. MEM_BYTES-4.
- clk  in  1  rising-edge clock.
- rst_n  in  1  one clock; reset is asynchronous and active-low.
- p0_req / p1_req  in  1  access request. The requester holds it and all fields stable until it sees gnt.
- p0_we / p1_we  in  1  1 = write word, 0 = read word.
- p0_addr / p1_addr  in  32  byte address.
- p0_wdata / p1_wdata  in  32  write data.
- p0_gnt / p1_gnt  out  1  combinational grant, same cycle as the request; at most one is high.
- p0_rvalid / p1_rvalid  out  1  one-cycle response pulse, in the cycle after the grant.
- p0_rdata / p1_rdata  out  32  read data; valid only with rvalid. It is 0 for writes and for errors.
- p0_err / p1_err  out  1  valid with rvalid. Set when the address is misaligned (addr[1:0] != 0) or above MEM_BYTES-4.
- mem_A  out  32  memory address.
- mem_WD  out  32  memory write data.
- mem_MemWrite  out  1  memory write enable.
- mem_RD  in  32  registered memory read data. It reflects mem_A of the previous cycle.

## Operation
- State: prio (1 bit, port favoured on a tie); response register {rsp_v, rsp_port, rsp_we, rsp_err}.
- Grant rule:
  - Only one port requesting: that port wins.
  - Both ports requesting: port prio wins.
  - After every grant to port k, prio becomes !k at the clock edge. With no grant, prio holds.
- Granted cycle:
  - mem_A and mem_WD = the winner's addr and wdata.
  - mem_MemWrite = winner's we AND NOT err.
- A bad access (err) is granted and consumes the slot. No write is performed. A read is still presented, but its data is discarded.
- No grant: mem_A = 0, mem_WD = 0, mem_MemWrite = 0.
- Edge after a grant: rsp_v=1, rsp_port=winner, rsp_we=we, rsp_err=err. Otherwise rsp_v=0.
- Response cycle:
  - p{rsp_port}_rvalid = rsp_v; the other port's rvalid is 0.
  - err = rsp_err.
  - rdata = (rsp_we | rsp_err) ? 0 : mem_RD.
- Range check: err = (addr[1:0] != 0) | (addr > MEM_BYTES-4), compared on the full 32 bits. addr = 0xFFFFFFFC is an error; there is no wrap-around.
- Back-to-back grants to the same or alternating ports are allowed every cycle. Each response pairs with its own grant, one cycle later.
- Hazards:
  - A read granted in the same cycle as a write to the same address cannot happen, because there is one grant per cycle.
  - A read granted the cycle after a write to the same word returns the new data.

## Timing
- Reset values (rst_n low, asynchronous):
  - prio=0 (port 0 favoured); rsp_v=0.
  - All gnt, rvalid and err = 0; rdata = 0.
  - mem_MemWrite = 0, mem_A = 0, mem_WD = 0. Grants are gated by rst_n.
- Latency: request→gnt is 0 cycles; gnt→rvalid is 1 cycle. Sustained throughput is 1 access per cycle.
- Reset asserted mid-operation:
  - A pending response is dropped (rvalid never pulses).
  - A write already clocked into memory stays committed.
  - After release, the first tie goes to port 0.
- A request dropped by the requester before grant is treated as never made. An rvalid owed for an earlier grant is still delivered.
- Memory is not reset. Reads of unwritten locations return its initial contents.

## Test plan
- Reset, then p0 reads addr 0x0 (mem bytes 11,22,33,44) → p0_gnt in cycle 0; p0_rvalid, p0_rdata=0x11223344, p0_err=0 in cycle 1; p1 signals stay 0.
- Tie: p0 and p1 both request for 4 cycles → grants p0,p1,p0,p1; rvalid alternates p0,p1,p0,p1 one cycle later.
- p1 writes 0xDEADBEEF to 0x10, then p0 reads 0x10 the next cycle → mem bytes DE,AD,BE,EF; p1_rdata=0; p0_rdata=0xDEADBEEF.
- Errors:
  - p1 write to 0x12 → p1_err=1, no memory change.
  - p0 read of 0x3FC (MEM_BYTES=1024) → err=0.
  - p0 read of 0x400 → err=1, rdata=0.
- Reset mid-flight: assert rst_n low between a p0 read grant and its response edge → p0_rvalid stays 0. After release, a tie grants p0 first.
- Single requester: p0_req held 6 cycles with p1 idle → p0 granted every cycle, 6 rvalid pulses, prio ends at 1.
